// File: rtl/rf_adc_sar_responder.sv
// ADC-side responder for the RF detector readout: decodes ADC_CTRL, samples one of
// four detector channels and runs an 8-bit SAR conversion, flagging EOC when done.
module rf_adc_sar_responder #(
  parameter int SAMPLE_CYCLES = 4,
  parameter int CLK_DIV       = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] adc_ctrl,
  input  logic [7:0] det1,
  input  logic [7:0] det2,
  input  logic [7:0] det3,
  input  logic [7:0] det4,
  output logic [7:0] adc_result,
  output logic       adc_eoc,
  output logic       busy,
  output logic       err_sel
);
  localparam int MAXC = (SAMPLE_CYCLES > CLK_DIV) ? SAMPLE_CYCLES : CLK_DIV;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  typedef enum logic [2:0] {OFF, IDLE, SAMPLE, CONVERT, DONE} state_t;

  state_t          state, nxt;
  logic            st_d;
  logic [7:0]      vin, sar, det_sel, trial;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_idx;

  logic       adc_en, clk_en, st_conv, start, go, sel_ok, keep;
  logic [2:0] mux_sel;
  logic       unused_ok;

  assign adc_en    = adc_ctrl[7];
  assign clk_en    = adc_ctrl[6];
  assign st_conv   = adc_ctrl[5];
  assign mux_sel   = adc_ctrl[2:0];
  assign unused_ok = ^adc_ctrl[4:3];

  assign start  = st_conv & ~st_d;
  assign go     = start & adc_en & clk_en;
  assign sel_ok = (mux_sel >= 3'd1) && (mux_sel <= 3'd4);
  assign trial  = sar | (8'd1 << bit_idx);
  assign keep   = (trial <= vin);

  always_comb begin
    det_sel = 8'd0;
    case (mux_sel)
      3'd1:    det_sel = det1;
      3'd2:    det_sel = det2;
      3'd3:    det_sel = det3;
      3'd4:    det_sel = det4;
      default: det_sel = 8'd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= OFF;
    else     state <= nxt;
  end

  // Dropping ADC_EN wins over every other transition.
  always_comb begin
    nxt = state;
    if (!adc_en) nxt = OFF;
    else begin
      case (state)
        OFF:        nxt = IDLE;
        IDLE, DONE: if (go && sel_ok) nxt = SAMPLE;
        SAMPLE:     if (clk_en && cnt == '0) nxt = CONVERT;
        CONVERT:    if (clk_en && cnt == '0 && bit_idx == 3'd0) nxt = DONE;
        default:    nxt = OFF;
      endcase
    end
  end

  always_comb begin
    busy = (state == SAMPLE) || (state == CONVERT);
  end

  // Datapath: clk_en low freezes cnt, bit_idx and sar in SAMPLE/CONVERT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_d       <= 1'b0;
      vin        <= 8'd0;
      sar        <= 8'd0;
      cnt        <= '0;
      bit_idx    <= 3'd0;
      adc_result <= 8'd0;
      adc_eoc    <= 1'b0;
      err_sel    <= 1'b0;
    end else begin
      st_d    <= st_conv;
      err_sel <= 1'b0;
      if (!adc_en) begin
        adc_eoc <= 1'b0;
        sar     <= 8'd0;
      end else begin
        case (state)
          IDLE, DONE: if (go) begin
            if (sel_ok) begin
              vin     <= det_sel;
              sar     <= 8'd0;
              adc_eoc <= 1'b0;
              cnt     <= CW'(SAMPLE_CYCLES - 1);
            end else begin
              err_sel <= 1'b1;
            end
          end
          SAMPLE: if (clk_en) begin
            if (cnt == '0) begin
              bit_idx <= 3'd7;
              cnt     <= CW'(CLK_DIV - 1);
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          CONVERT: if (clk_en) begin
            if (cnt == '0) begin
              if (keep) sar <= trial;
              if (bit_idx == 3'd0) begin
                adc_result <= keep ? trial : sar;
                adc_eoc    <= 1'b1;
              end else begin
                bit_idx <= bit_idx - 3'd1;
                cnt     <= CW'(CLK_DIV - 1);
              end
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_rf_adc_sar_responder.sv
// Bench for rf_adc_sar_responder: abstract countdown model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_rf_adc_sar_responder;
  localparam int SC = 4;
  localparam int CD = 2;

  logic       clk, rst;
  logic [7:0] adc_ctrl, det1, det2, det3, det4;
  logic [7:0] adc_result;
  logic       adc_eoc, busy, err_sel;

  int n_chk  = 0;
  int n_pass = 0;

  rf_adc_sar_responder #(.SAMPLE_CYCLES(SC), .CLK_DIV(CD)) dut (
    .clk(clk), .rst(rst), .adc_ctrl(adc_ctrl),
    .det1(det1), .det2(det2), .det3(det3), .det4(det4),
    .adc_result(adc_result), .adc_eoc(adc_eoc), .busy(busy), .err_sel(err_sel)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: a conversion is a fixed budget of enabled clocks, after which the
  // result is simply the latched detector level.
  logic       m_on, m_busy, m_eoc, m_err, m_std;
  logic [7:0] m_vin, m_res;
  int         m_rem;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_on = 0; m_busy = 0; m_eoc = 0; m_err = 0; m_std = 0;
      m_vin = 0; m_res = 0; m_rem = 0;
    end else begin : step
      logic st, en, ce, strt;
      logic [2:0] sel;
      en = adc_ctrl[7]; ce = adc_ctrl[6]; st = adc_ctrl[5]; sel = adc_ctrl[2:0];
      strt  = st & ~m_std;
      m_std = st;
      m_err = 0;
      if (!en) begin
        m_on = 0; m_busy = 0; m_eoc = 0;
      end else if (!m_on) begin
        m_on = 1;
      end else if (m_busy) begin
        if (ce) begin
          m_rem--;
          if (m_rem == 0) begin
            m_busy = 0; m_res = m_vin; m_eoc = 1;
          end
        end
      end else if (strt && ce) begin
        if (sel >= 1 && sel <= 4) begin
          case (sel)
            3'd1: m_vin = det1;
            3'd2: m_vin = det2;
            3'd3: m_vin = det3;
            default: m_vin = det4;
          endcase
          m_rem = SC + 8 * CD; m_busy = 1; m_eoc = 0;
        end else begin
          m_err = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("cyc_result", adc_result, m_res);
      chk("cyc_eoc", adc_eoc, m_eoc);
      chk("cyc_busy", busy, m_busy);
      chk("cyc_err", err_sel, m_err);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1; adc_ctrl = 8'h00;
    det1 = 8'h00; det2 = 8'h00; det3 = 8'h00; det4 = 8'h00;
    #1;
    chk("rst_result", adc_result, 0);
    chk("rst_eoc", adc_eoc, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_sel, 0);
    tick(2);
    rst = 0;

    // T1: basic conversion, 20-cycle latency
    adc_ctrl = 8'hC1; det1 = 8'hA5;
    tick(1);
    adc_ctrl = 8'hE1;
    tick(1);
    chk("t1_busy", busy, 1);
    tick(19);
    chk("t1_eoc_early", adc_eoc, 0);
    tick(1);
    chk("t1_eoc", adc_eoc, 1);
    chk("t1_result", adc_result, 8'hA5);
    chk("t1_model", m_res, 8'hA5);
    adc_ctrl = 8'hC1;
    tick(1);

    // T2: channel sweep with 0/255 boundaries
    det1 = 8'h00; det2 = 8'hFF; det3 = 8'h80; det4 = 8'h7F;
    for (int s = 1; s <= 4; s++) begin
      logic [7:0] exp_v;
      case (s)
        1: exp_v = 8'h00;
        2: exp_v = 8'hFF;
        3: exp_v = 8'h80;
        default: exp_v = 8'h7F;
      endcase
      adc_ctrl = 8'hE0 | 8'(s);
      tick(1);
      tick(20);
      chk("t2_eoc", adc_eoc, 1);
      chk("t2_result", adc_result, exp_v);
      adc_ctrl = 8'hC0 | 8'(s);
      tick(1);
    end

    // T3: illegal MUX_SEL -> one-cycle err_sel, nothing else changes
    for (int k = 0; k < 2; k++) begin
      logic [2:0] bad;
      bad = (k == 0) ? 3'd0 : 3'd7;
      adc_ctrl = {5'b11000, bad};
      tick(1);
      adc_ctrl = {5'b11100, bad};
      tick(1);
      chk("t3_err", err_sel, 1);
      chk("t3_busy", busy, 0);
      tick(1);
      chk("t3_err_clr", err_sel, 0);
      chk("t3_result", adc_result, 8'h7F);
      chk("t3_eoc", adc_eoc, 1);
    end
    adc_ctrl = 8'hC1;
    tick(1);

    // T4: CLK_EN low for 5 cycles mid-CONVERT stretches latency to 25
    det1 = 8'h3C;
    adc_ctrl = 8'hE1;
    tick(1);
    tick(8);
    adc_ctrl = 8'hA1;
    tick(5);
    chk("t4_busy_frozen", busy, 1);
    adc_ctrl = 8'hE1;
    tick(11);
    chk("t4_eoc_early", adc_eoc, 0);
    tick(1);
    chk("t4_eoc", adc_eoc, 1);
    chk("t4_result", adc_result, 8'h3C);
    adc_ctrl = 8'hC1;
    tick(1);

    // T5: ADC_EN drop mid-CONVERT, then a clean restart
    det2 = 8'hFF;
    adc_ctrl = 8'hC2;
    tick(1);
    adc_ctrl = 8'hE2;
    tick(1);
    tick(9);
    adc_ctrl = 8'h62;
    tick(1);
    chk("t5_busy", busy, 0);
    chk("t5_eoc", adc_eoc, 0);
    chk("t5_result", adc_result, 8'h3C);
    adc_ctrl = 8'hC2;
    tick(1);
    adc_ctrl = 8'hE2;
    tick(1);
    tick(19);
    chk("t5_eoc_early", adc_eoc, 0);
    tick(1);
    chk("t5_eoc_re", adc_eoc, 1);
    chk("t5_result_re", adc_result, 8'hFF);
    chk("t5_model", m_res, 8'hFF);

    // T6: retrigger while busy is ignored; vin latched at start
    adc_ctrl = 8'hC2;
    tick(1);
    det2 = 8'h5A;
    adc_ctrl = 8'hE2;
    tick(1);
    det2 = 8'h11;
    adc_ctrl = 8'hC2;
    tick(1);
    adc_ctrl = 8'hE2;
    tick(1);
    chk("t6_busy", busy, 1);
    chk("t6_err", err_sel, 0);
    tick(18);
    chk("t6_eoc", adc_eoc, 1);
    chk("t6_result", adc_result, 8'h5A);

    // T6: async reset mid-SAMPLE
    adc_ctrl = 8'hC2;
    tick(1);
    adc_ctrl = 8'hE2;
    tick(1);
    tick(2);
    chk("t6_pre_rst_busy", busy, 1);
    rst = 1;
    #1;
    chk("t6_rst_result", adc_result, 0);
    chk("t6_rst_eoc", adc_eoc, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_err", err_sel, 0);
    tick(2);
    rst = 0;
    tick(3);
    chk("t6_post_busy", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
